hsci_phy_lane_align: RTL and testbench

Parametrised per-lane receive back-end for the HSCI PHY. It sits between the SelectIO receive FIFOs and the HSCI link layer, all in the PHY pclk domain. For each of NUM_LANES lanes it:
- generates the FIFO read enables;
- optionally bit-reverses the deserialised words;
- locates the word boundary using the sampled MISO clock word, then word-aligns the data with a barrel window;
- qualifies output data with a per-lane lock FSM that carries hysteresis and error counters.

---
 rtl/hsci_phy_lane_align.sv | 201 ++++++++++++++++++++
 tb/tb_hsci_phy_lane_align.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsci_phy_lane_align.sv
// hsci_phy_lane_align
//   Per-lane receive back-end for the HSCI PHY (pclk domain). For each lane it
//   drives the RX FIFO read enable, optionally bit-reverses the deserialised
//   data and clock words, and word-aligns both with a barrel window over the
//   current and previous word. The offset is found by searching for
//   CLK_PATTERN in the sampled MISO clock word. Output data is qualified by
//   a lock FSM with hysteresis and a saturating error counter.
//
// Ports
//   clk          pclk, single clock for all logic
//   resetn       asynchronous active-low reset
//   phy_ready    PHY bank ready (reset sequence done and PLL locked)
//   realign      per-lane pulse forcing a re-search at the current offset
//   fifo_empty   per-lane RX FIFO empty flag
//   fifo_rd_en   per-lane RX FIFO read enable (combinational)
//   fifo_data    per-lane data word, valid the cycle after fifo_rd_en
//   fifo_clk     per-lane sampled clock word, same timing as fifo_data
//   data_out     per-lane aligned data word
//   data_valid   per-lane qualifier for data_out
//   lane_locked  per-lane LOCKED indication
//   lane_offset  per-lane bit offset of the alignment window
//   lane_err_cnt per-lane saturating clock-mismatch count while LOCKED
module hsci_phy_lane_align #(
    parameter int                    NUM_LANES    = 4,
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] CLK_PATTERN  = 8'hF0,
    parameter int                    BIT_REVERSE  = 1,
    parameter int                    LOCK_COUNT   = 16,
    parameter int                    UNLOCK_COUNT = 4
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic                                    phy_ready,
    input  logic [NUM_LANES-1:0]                    realign,
    input  logic [NUM_LANES-1:0]                    fifo_empty,
    output logic [NUM_LANES-1:0]                    fifo_rd_en,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]         fifo_data,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]         fifo_clk,
    output logic [NUM_LANES*DATA_WIDTH-1:0]         data_out,
    output logic [NUM_LANES-1:0]                    data_valid,
    output logic [NUM_LANES-1:0]                    lane_locked,
    output logic [NUM_LANES*$clog2(DATA_WIDTH)-1:0] lane_offset,
    output logic [NUM_LANES*8-1:0]                  lane_err_cnt
);

    localparam int         OFF_W      = $clog2(DATA_WIDTH);
    localparam logic [7:0] LOCK_MAX   = 8'(LOCK_COUNT);
    localparam logic [7:0] UNLOCK_MAX = 8'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } lane_state_t;

    function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] y;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            y[b] = x[DATA_WIDTH-1-b];
        end
        return y;
    endfunction

    assign fifo_rd_en = {NUM_LANES{phy_ready}} & ~fifo_empty;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lane_state_t           state_q, state_d;
        logic [OFF_W-1:0]      off_q, off_d;
        logic [7:0]            match_q, match_d;
        logic [7:0]            miss_q, miss_d;
        logic [7:0]            err_q, err_d;
        logic                  vld_p1;
        logic [DATA_WIDTH-1:0] word_d_p1, word_c_p1;
        logic [DATA_WIDTH-1:0] hold_d_q, hold_c_q;
        logic [DATA_WIDTH-1:0] win_d_p1, win_c_p1;
        logic                  clk_match;
        logic [DATA_WIDTH-1:0] dout_p2;
        logic                  dval_p2;

        // ---- stage p1: word present on the FIFO outputs, window alignment
        assign word_d_p1 = (BIT_REVERSE != 0) ? bit_rev(fifo_data[g*DATA_WIDTH +: DATA_WIDTH])
                                              : fifo_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign word_c_p1 = (BIT_REVERSE != 0) ? bit_rev(fifo_clk[g*DATA_WIDTH +: DATA_WIDTH])
                                              : fifo_clk[g*DATA_WIDTH +: DATA_WIDTH];

        // Current word on top, previous word below: offset k takes the upper
        // W-k bits of the previous word and the lower k bits of the current.
        assign win_d_p1  = DATA_WIDTH'({word_d_p1, hold_d_q} >> off_q);
        assign win_c_p1  = DATA_WIDTH'({word_c_p1, hold_c_q} >> off_q);
        assign clk_match = (win_c_p1 == CLK_PATTERN);

        always_comb begin
            state_d = state_q;
            off_d   = off_q;
            match_d = match_q;
            miss_d  = miss_q;
            err_d   = err_q;
            if (!phy_ready) begin
                state_d = ST_IDLE;
                off_d   = '0;
                match_d = '0;
                miss_d  = '0;
            end else if (realign[g]) begin
                state_d = ST_SEARCH;
                match_d = '0;
                miss_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_SEARCH;
                    ST_SEARCH: begin
                        if (vld_p1) begin
                            if (clk_match) begin
                                state_d = ST_VERIFY;
                                match_d = 8'd1;
                            end else begin
                                off_d = off_q + 1'b1;  // W is a power of 2: wraps to 0
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (vld_p1) begin
                            if (clk_match) begin
                                match_d = match_q + 8'd1;
                                if (match_d == LOCK_MAX) begin
                                    state_d = ST_LOCKED;
                                    match_d = '0;
                                end
                            end else begin
                                state_d = ST_SEARCH;
                                off_d   = off_q + 1'b1;
                                match_d = '0;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (vld_p1) begin
                            if (clk_match) begin
                                miss_d = '0;
                            end else begin
                                miss_d = miss_q + 8'd1;
                                if (err_q != 8'hFF) begin
                                    err_d = err_q + 8'd1;
                                end
                                // Offset kept so the current alignment is retested first.
                                if (miss_d == UNLOCK_MAX) begin
                                    state_d = ST_SEARCH;
                                    miss_d  = '0;
                                end
                            end
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_IDLE;
                off_q   <= '0;
                match_q <= '0;
                miss_q  <= '0;
                err_q   <= '0;
            end else begin
                state_q <= state_d;
                off_q   <= off_d;
                match_q <= match_d;
                miss_q  <= miss_d;
                err_q   <= err_d;
            end
        end

        // ---- stage p0 -> p1: word-present strobe; p1 -> p2: hold and output registers
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                vld_p1   <= 1'b0;
                hold_d_q <= '0;
                hold_c_q <= '0;
                dout_p2  <= '0;
                dval_p2  <= 1'b0;
            end else begin
                vld_p1  <= fifo_rd_en[g];
                // A word in flight when phy_ready drops is still captured, never qualified.
                dval_p2 <= vld_p1 & phy_ready & ~realign[g] & (state_q == ST_LOCKED) & clk_match;
                if (vld_p1) begin
                    hold_d_q <= word_d_p1;
                    hold_c_q <= word_c_p1;
                    dout_p2  <= win_d_p1;
                end
            end
        end

        assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = dout_p2;
        assign data_valid[g]                        = dval_p2;
        assign lane_locked[g]                       = (state_q == ST_LOCKED);
        assign lane_offset[g*OFF_W +: OFF_W]        = off_q;
        assign lane_err_cnt[g*8 +: 8]               = err_q;
    end

endmodule

// File: tb/tb_hsci_phy_lane_align.sv
module tb_hsci_phy_lane_align;

    localparam int         NL      = 4;
    localparam int         W       = 8;
    localparam logic [7:0] PAT     = 8'hF0;
    localparam int         LOCKN   = 16;
    localparam int         UNLOCKN = 4;

    localparam int M_IDLE   = 0;
    localparam int M_SEARCH = 1;
    localparam int M_VERIFY = 2;
    localparam int M_LOCKED = 3;

    logic            clk = 1'b0;
    logic            resetn;
    logic            phy_ready;
    logic [NL-1:0]   realign;
    logic [NL-1:0]   fifo_empty;
    logic [NL-1:0]   fifo_rd_en;
    logic [NL*W-1:0] fifo_data;
    logic [NL*W-1:0] fifo_clk;
    logic [NL*W-1:0] data_out;
    logic [NL-1:0]   data_valid;
    logic [NL-1:0]   lane_locked;
    logic [NL*3-1:0] lane_offset;
    logic [NL*8-1:0] lane_err_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Each lane's raw clock stream is CLK_PATTERN rotated left by rot[l]
    // (in the bit-reversed domain), so lane l must settle at offset rot[l].
    int rot [NL] = '{3, 5, 0, 6};
    bit bad [NL];

    // Reference model state, one entry per lane
    int         m_st   [NL];
    bit         m_v    [NL];
    bit         m_used [NL];
    logic [7:0] m_hd   [NL];
    logic [7:0] m_hc   [NL];
    logic [7:0] m_dout [NL];
    bit         m_dval [NL];
    int         m_off  [NL];
    int         m_mc   [NL];
    int         m_miss [NL];
    int         m_err  [NL];

    hsci_phy_lane_align #(
        .NUM_LANES   (NL),
        .DATA_WIDTH  (W),
        .CLK_PATTERN (PAT),
        .BIT_REVERSE (1),
        .LOCK_COUNT  (LOCKN),
        .UNLOCK_COUNT(UNLOCKN)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .phy_ready   (phy_ready),
        .realign     (realign),
        .fifo_empty  (fifo_empty),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_data   (fifo_data),
        .fifo_clk    (fifo_clk),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .lane_locked (lane_locked),
        .lane_offset (lane_offset),
        .lane_err_cnt(lane_err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) y[i] = x[7-i];
        return y;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic void model_reset();
        for (int l = 0; l < NL; l++) begin
            m_st[l] = M_IDLE; m_v[l] = 0; m_used[l] = 0; m_hd[l] = 0; m_hc[l] = 0;
            m_dout[l] = 0; m_dval[l] = 0; m_off[l] = 0; m_mc[l] = 0; m_miss[l] = 0; m_err[l] = 0;
        end
    endfunction

    // One clock edge of the behaviour, evaluated from the inputs before the edge.
    function automatic void model_step();
        for (int l = 0; l < NL; l++) begin
            logic [7:0]  rd_w, rc_w, wd, wc;
            logic [15:0] cat;
            bit          hit;
            bit          word_now;
            word_now  = m_v[l];
            hit       = 0;
            m_used[l] = word_now;
            m_dval[l] = 0;
            if (word_now) begin
                rd_w = rev8(fifo_data[l*W +: W]);
                rc_w = rev8(fifo_clk[l*W +: W]);
                cat  = {rd_w, m_hd[l]} >> m_off[l];
                wd   = cat[7:0];
                cat  = {rc_w, m_hc[l]} >> m_off[l];
                wc   = cat[7:0];
                hit  = (wc == PAT);
                m_hd[l]   = rd_w;
                m_hc[l]   = rc_w;
                m_dout[l] = wd;
                m_dval[l] = phy_ready && !realign[l] && (m_st[l] == M_LOCKED) && hit;
            end
            if (!phy_ready) begin
                m_st[l] = M_IDLE; m_off[l] = 0; m_mc[l] = 0; m_miss[l] = 0;
            end else if (realign[l]) begin
                m_st[l] = M_SEARCH; m_mc[l] = 0; m_miss[l] = 0;
            end else if (m_st[l] == M_IDLE) begin
                m_st[l] = M_SEARCH;
            end else if (word_now) begin
                if (m_st[l] == M_SEARCH) begin
                    if (hit) begin m_st[l] = M_VERIFY; m_mc[l] = 1; end
                    else m_off[l] = (m_off[l] + 1) % W;
                end else if (m_st[l] == M_VERIFY) begin
                    if (hit) begin
                        m_mc[l]++;
                        if (m_mc[l] == LOCKN) begin m_st[l] = M_LOCKED; m_mc[l] = 0; end
                    end else begin
                        m_st[l] = M_SEARCH; m_off[l] = (m_off[l] + 1) % W; m_mc[l] = 0;
                    end
                end else begin
                    if (hit) m_miss[l] = 0;
                    else begin
                        m_miss[l]++;
                        if (m_err[l] < 255) m_err[l]++;
                        if (m_miss[l] == UNLOCKN) begin m_st[l] = M_SEARCH; m_miss[l] = 0; end
                    end
                end
            end
            m_v[l] = phy_ready && !fifo_empty[l];
        end
    endfunction

    task automatic drive_words();
        for (int l = 0; l < NL; l++) begin
            logic [7:0] rc;
            rc = rotl8(PAT, rot[l]);
            if (bad[l]) rc = rc ^ 8'h01;
            fifo_clk[l*W +: W]  = rev8(rc);
            fifo_data[l*W +: W] = 8'($urandom);
        end
    endtask

    // Present this cycle's words, clock once, advance the model, settle 1 time unit.
    task automatic tick();
        drive_words();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
        realign = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; phy_ready = 1'b0; realign = '0; fifo_empty = '0;
        for (int l = 0; l < NL; l++) bad[l] = 0;
        model_reset();
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; phy_ready = 1'b0; fifo_empty = '0; realign = '0;
        model_reset();
        repeat (2) tick();
        tests_run++; if (fifo_rd_en !== '0) begin tests_failed++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        tests_run++; if (data_valid !== '0) begin tests_failed++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
        tests_run++; if (lane_locked !== '0) begin tests_failed++; $display("FAIL reset_locked got=%b exp=0", lane_locked); end
        tests_run++; if (lane_offset !== '0) begin tests_failed++; $display("FAIL reset_offset got=%h exp=0", lane_offset); end
        tests_run++; if (lane_err_cnt !== '0) begin tests_failed++; $display("FAIL reset_err got=%h exp=0", lane_err_cnt); end
        resetn = 1'b1;
        repeat (2) tick();
        tests_run++; if (fifo_rd_en !== '0) begin tests_failed++; $display("FAIL idle_rd_en got=%b exp=0", fifo_rd_en); end
        tests_run++; if (lane_offset !== '0) begin tests_failed++; $display("FAIL idle_offset got=%h exp=0", lane_offset); end
    endtask

    task automatic test_lock_offset();
        int lock_t = -1;
        int dv_t = -1;
        logic [NL-1:0] ev, el;
        do_reset();
        phy_ready = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            for (int l = 0; l < NL; l++) begin ev[l] = m_dval[l]; el[l] = (m_st[l] == M_LOCKED); end
            tests_run++; if (lane_locked[0] !== (t >= 20)) begin tests_failed++; $display("FAIL lock_l0 t=%0d got=%b exp=%b", t, lane_locked[0], (t >= 20)); end
            tests_run++; if (lane_locked !== el) begin tests_failed++; $display("FAIL lock_model t=%0d got=%b exp=%b", t, lane_locked, el); end
            tests_run++; if (data_valid !== ev) begin tests_failed++; $display("FAIL dval_model t=%0d got=%b exp=%b", t, data_valid, ev); end
            tests_run++; if (lane_offset[2:0] !== 3'(m_off[0])) begin tests_failed++; $display("FAIL offset_l0 t=%0d got=%0d exp=%0d", t, lane_offset[2:0], m_off[0]); end
            if (m_dval[0]) begin
                tests_run++; if (data_out[7:0] !== m_dout[0]) begin tests_failed++; $display("FAIL dout_l0 t=%0d got=%h exp=%h", t, data_out[7:0], m_dout[0]); end
            end
            if (lane_locked[0] && lock_t < 0) lock_t = t;
            if (data_valid[0] && dv_t < 0) dv_t = t;
        end
        tests_run++; if (lock_t != 20) begin tests_failed++; $display("FAIL lock_time got=%0d exp=20", lock_t); end
        tests_run++; if (dv_t != 21) begin tests_failed++; $display("FAIL first_valid got=%0d exp=21", dv_t); end
        for (int l = 0; l < NL; l++) begin
            tests_run++; if (lane_offset[l*3 +: 3] !== 3'(rot[l])) begin tests_failed++; $display("FAIL final_offset lane=%0d got=%0d exp=%0d", l, lane_offset[l*3 +: 3], rot[l]); end
        end
        tests_run++; if (lane_locked !== 4'hF) begin tests_failed++; $display("FAIL all_locked got=%b exp=1111", lane_locked); end
    endtask

    task automatic test_fifo_stall();
        int words = 0;
        int lock_words = -1;
        bit prev_rd = 0;
        bit rd_now;
        logic [NL-1:0] ev;
        do_reset();
        phy_ready = 1'b1;
        for (int t = 1; t <= 80; t++) begin
            fifo_empty = (t % 2 == 1) ? '1 : '0;
            rd_now = phy_ready && !fifo_empty[0];
            tick();
            for (int l = 0; l < NL; l++) ev[l] = m_dval[l];
            if (prev_rd) words++;
            tests_run++; if (data_valid[0] && !prev_rd) begin tests_failed++; $display("FAIL stall_valid t=%0d got=1 exp=0", t); end
            tests_run++; if (data_valid !== ev) begin tests_failed++; $display("FAIL stall_dval_model t=%0d got=%b exp=%b", t, data_valid, ev); end
            if (m_dval[0]) begin
                tests_run++; if (data_out[7:0] !== m_dout[0]) begin tests_failed++; $display("FAIL stall_dout t=%0d got=%h exp=%h", t, data_out[7:0], m_dout[0]); end
            end
            if (lane_locked[0] && lock_words < 0) lock_words = words;
            prev_rd = rd_now;
        end
        tests_run++; if (lock_words != 19) begin tests_failed++; $display("FAIL stall_lock_words got=%0d exp=19", lock_words); end
        fifo_empty = '0;
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        phy_ready = 1'b1;
        repeat (25) tick();
        tests_run++; if (lane_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_pre_lock got=%b exp=1", lane_locked[0]); end
        bad[0] = 1;
        repeat (3) tick();
        tests_run++; if (lane_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_3bad_lock got=%b exp=1", lane_locked[0]); end
        tests_run++; if (lane_err_cnt[7:0] !== 8'd3) begin tests_failed++; $display("FAIL loss_3bad_err got=%0d exp=3", lane_err_cnt[7:0]); end
        bad[0] = 0;
        tick();
        tests_run++; if (lane_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_good_lock got=%b exp=1", lane_locked[0]); end
        bad[0] = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests_run++; if (lane_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_bad%0d_lock got=%b exp=1", k, lane_locked[0]); end
        end
        tick();
        bad[0] = 0;
        tests_run++; if (lane_locked[0] !== 1'b0) begin tests_failed++; $display("FAIL loss_unlock got=%b exp=0", lane_locked[0]); end
        tests_run++; if (lane_err_cnt[7:0] !== 8'd7) begin tests_failed++; $display("FAIL loss_err got=%0d exp=7", lane_err_cnt[7:0]); end
        tests_run++; if (lane_offset[2:0] !== 3'd3) begin tests_failed++; $display("FAIL loss_offset got=%0d exp=3", lane_offset[2:0]); end
        tests_run++; if (lane_err_cnt[31:8] !== '0) begin tests_failed++; $display("FAIL loss_other_err got=%h exp=0", lane_err_cnt[31:8]); end
        repeat (20) tick();
        tests_run++; if (lane_locked[0] !== 1'b1) begin tests_failed++; $display("FAIL loss_relock got=%b exp=1", lane_locked[0]); end
        tests_run++; if (lane_err_cnt[7:0] !== 8'(m_err[0])) begin tests_failed++; $display("FAIL loss_err_hold got=%0d exp=%0d", lane_err_cnt[7:0], m_err[0]); end
    endtask

    task automatic test_async_reset();
        tests_run++; if (lane_err_cnt[7:0] === 8'd0) begin tests_failed++; $display("FAIL areset_pre_err got=0 exp=nonzero"); end
        resetn = 1'b0;
        model_reset();
        #2;
        tests_run++; if (lane_locked !== '0) begin tests_failed++; $display("FAIL areset_locked got=%b exp=0", lane_locked); end
        tests_run++; if (lane_err_cnt !== '0) begin tests_failed++; $display("FAIL areset_err got=%h exp=0", lane_err_cnt); end
        tests_run++; if (data_out !== '0) begin tests_failed++; $display("FAIL areset_dout got=%h exp=0", data_out); end
        tests_run++; if (lane_offset !== '0) begin tests_failed++; $display("FAIL areset_offset got=%h exp=0", lane_offset); end
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic test_realign();
        int relock_k = -1;
        logic [NL-1:0] el, ev;
        do_reset();
        phy_ready = 1'b1;
        repeat (40) tick();
        tests_run++; if (lane_locked !== 4'hF) begin tests_failed++; $display("FAIL realign_pre got=%b exp=1111", lane_locked); end
        realign = 4'b0100;
        tick();
        tests_run++; if (lane_locked !== 4'b1011) begin tests_failed++; $display("FAIL realign_drop got=%b exp=1011", lane_locked); end
        tests_run++; if ((data_valid & 4'b1011) !== 4'b1011) begin tests_failed++; $display("FAIL realign_others got=%b exp=x1x11", data_valid); end
        tests_run++; if (lane_offset[8:6] !== 3'(rot[2])) begin tests_failed++; $display("FAIL realign_offset got=%0d exp=%0d", lane_offset[8:6], rot[2]); end
        for (int k = 1; k <= 25; k++) begin
            tick();
            for (int l = 0; l < NL; l++) begin ev[l] = m_dval[l]; el[l] = (m_st[l] == M_LOCKED); end
            tests_run++; if ((data_valid & 4'b1011) !== 4'b1011) begin tests_failed++; $display("FAIL realign_cont k=%0d got=%b exp=x1x11", k, data_valid); end
            tests_run++; if (lane_locked !== el) begin tests_failed++; $display("FAIL realign_lock_model k=%0d got=%b exp=%b", k, lane_locked, el); end
            tests_run++; if (data_valid !== ev) begin tests_failed++; $display("FAIL realign_dval_model k=%0d got=%b exp=%b", k, data_valid, ev); end
            if (lane_locked[2] && relock_k < 0) relock_k = k;
        end
        tests_run++; if (relock_k != 16) begin tests_failed++; $display("FAIL realign_relock got=%0d exp=16", relock_k); end
    endtask

    task automatic test_phy_ready_drop();
        do_reset();
        phy_ready = 1'b1;
        repeat (8) tick();
        tests_run++; if (lane_locked[0] !== 1'b0 || lane_offset[2:0] !== 3'd3) begin tests_failed++; $display("FAIL drop_pre got=%b/%0d exp=0/3", lane_locked[0], lane_offset[2:0]); end
        phy_ready = 1'b0;
        #1;
        tests_run++; if (fifo_rd_en !== '0) begin tests_failed++; $display("FAIL drop_rd_en got=%b exp=0", fifo_rd_en); end
        tick();
        tests_run++; if (lane_offset !== '0) begin tests_failed++; $display("FAIL drop_offset got=%h exp=0", lane_offset); end
        tests_run++; if (data_valid !== '0) begin tests_failed++; $display("FAIL drop_dval got=%b exp=0", data_valid); end
        tests_run++; if (data_out[7:0] !== m_dout[0]) begin tests_failed++; $display("FAIL drop_inflight got=%h exp=%h", data_out[7:0], m_dout[0]); end
        tick();
        tests_run++; if (data_out[7:0] !== m_dout[0]) begin tests_failed++; $display("FAIL drop_hold got=%h exp=%h", data_out[7:0], m_dout[0]); end
        phy_ready = 1'b1;
        tick();
        tests_run++; if (lane_offset !== '0) begin tests_failed++; $display("FAIL restart_offset got=%h exp=0", lane_offset); end
        for (int t = 1; t <= 30; t++) begin
            tick();
            tests_run++; if (lane_offset[2:0] !== 3'(m_off[0])) begin tests_failed++; $display("FAIL restart_off_model t=%0d got=%0d exp=%0d", t, lane_offset[2:0], m_off[0]); end
            tests_run++; if (lane_locked[0] !== (m_st[0] == M_LOCKED)) begin tests_failed++; $display("FAIL restart_lock_model t=%0d got=%b", t, lane_locked[0]); end
        end
        tests_run++; if (lane_locked[0] !== 1'b1 || lane_offset[2:0] !== 3'd3) begin tests_failed++; $display("FAIL restart_final got=%b/%0d exp=1/3", lane_locked[0], lane_offset[2:0]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; phy_ready = 1'b0; realign = '0; fifo_empty = '0;
        fifo_data = '0; fifo_clk = '0;
        for (int l = 0; l < NL; l++) bad[l] = 0;
        model_reset();
        test_reset();
        test_lock_offset();
        test_fifo_stall();
        test_loss_of_lock();
        test_async_reset();
        test_realign();
        test_phy_ready_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
